// File: rtl/rtc_timekeeper_if.sv
// rtl/rtc_timekeeper_if.sv - control, edit, alarm and status bundle for rtc_timekeeper
interface rtc_timekeeper_if;
  logic       start, stop, edit;
  logic [5:0] e_sec, e_minute;
  logic [4:0] e_hour;
  logic       e_pm;
  logic       al_set;
  logic [4:0] al_hour;
  logic [5:0] al_minute;
  logic       al_pm, al_arm, al_ack, snooze;
  logic [5:0] second, minute;
  logic [4:0] hour;
  logic       pm, sec_tick, edit_err, alarm;
  logic       idle_mode, run_mode, edit_mode, stop_mode;

  modport master (
    output start, stop, edit, e_sec, e_minute, e_hour, e_pm,
    output al_set, al_hour, al_minute, al_pm, al_arm, al_ack, snooze,
    input  second, minute, hour, pm, sec_tick, edit_err, alarm,
    input  idle_mode, run_mode, edit_mode, stop_mode
  );

  modport slave (
    input  start, stop, edit, e_sec, e_minute, e_hour, e_pm,
    input  al_set, al_hour, al_minute, al_pm, al_arm, al_ack, snooze,
    output second, minute, hour, pm, sec_tick, edit_err, alarm,
    output idle_mode, run_mode, edit_mode, stop_mode
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - h:m:s timekeeper, 24h/12h modes; optional alarm/snooze under ALARM_EN
module rtc_timekeeper #(
  parameter int CLK_FRQ    = 100000000,
  parameter int HOUR_MODE  = 0,
  parameter int SNOOZE_MIN = 5
) (
  input logic             clk,
  input logic             rst,
  rtc_timekeeper_if.slave bus
);
  localparam int         PW       = $clog2(CLK_FRQ);
  localparam logic [4:0] HOUR_RST = (HOUR_MODE != 0) ? 5'd12 : 5'd0;

  typedef enum logic [1:0] {IDLE, RUN, EDIT, STOP} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pres;
  logic          tick, edit_ok, edit_pm, edit_bad, al_bad;
  logic [5:0]    n_sec, n_min;
  logic [4:0]    n_hour;
  logic          n_pm;

  function automatic logic hour_ok(input logic [4:0] h);
    if (HOUR_MODE != 0) return (h >= 5'd1) && (h <= 5'd12);
    return h <= 5'd23;
  endfunction

  // Hour after a minute rollover, returned as {pm, hour}; 12h flips pm on 11 -> 12.
  function automatic logic [5:0] hour_inc(input logic [4:0] h, input logic p);
    if (HOUR_MODE != 0) begin
      if (h == 5'd12) return {p, 5'd1};
      if (h == 5'd11) return {~p, 5'd12};
      return {p, h + 5'd1};
    end
    if (h == 5'd23) return 6'd0;
    return {(h + 5'd1) >= 5'd12, h + 5'd1};
  endfunction

  always_comb begin
    n_sec  = bus.second + 6'd1;
    n_min  = bus.minute;
    n_hour = bus.hour;
    n_pm   = bus.pm;
    if (bus.second == 6'd59) begin
      n_sec = 6'd0;
      n_min = bus.minute + 6'd1;
      if (bus.minute == 6'd59) begin
        n_min          = 6'd0;
        {n_pm, n_hour} = hour_inc(bus.hour, bus.pm);
      end
    end
  end

  assign tick     = (state == RUN) && !bus.stop && !bus.edit && (pres == PW'(CLK_FRQ - 1));
  assign edit_ok  = (bus.e_sec <= 6'd59) && (bus.e_minute <= 6'd59) && hour_ok(bus.e_hour);
  assign edit_pm  = (HOUR_MODE != 0) ? bus.e_pm : (bus.e_hour >= 5'd12);
  assign edit_bad = (state == EDIT) && !edit_ok;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
            else if (bus.edit) state_nx = EDIT;
      RUN:  if (bus.stop) state_nx = STOP;
            else if (bus.edit) state_nx = EDIT;
      EDIT: if (bus.start) state_nx = RUN;
            else if (bus.stop) state_nx = STOP;
            else if (!bus.edit) state_nx = IDLE;
      STOP: if (bus.start) state_nx = RUN;
            else if (bus.edit) state_nx = EDIT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pres          <= '0;
      bus.second    <= 6'd0;
      bus.minute    <= 6'd0;
      bus.hour      <= HOUR_RST;
      bus.pm        <= 1'b0;
      bus.sec_tick  <= 1'b0;
      bus.edit_err  <= 1'b0;
      bus.idle_mode <= 1'b1;
      bus.run_mode  <= 1'b0;
      bus.edit_mode <= 1'b0;
      bus.stop_mode <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.idle_mode <= (state_nx == IDLE);
      bus.run_mode  <= (state_nx == RUN);
      bus.edit_mode <= (state_nx == EDIT);
      bus.stop_mode <= (state_nx == STOP);
      bus.sec_tick  <= tick;
      bus.edit_err  <= edit_bad | al_bad;
      case (state)
        IDLE: pres <= '0;
        RUN: begin
          if (!bus.stop && !bus.edit) begin
            pres <= tick ? '0 : pres + PW'(1);
            if (tick) begin
              bus.second <= n_sec;
              bus.minute <= n_min;
              bus.hour   <= n_hour;
              bus.pm     <= n_pm;
            end
          end
        end
        EDIT: begin
          pres <= '0;
          if (edit_ok) begin
            bus.second <= bus.e_sec;
            bus.minute <= bus.e_minute;
            bus.hour   <= bus.e_hour;
            bus.pm     <= edit_pm;
          end
        end
        default: ;  // STOP holds the sub-second phase
      endcase
    end
  end

`ifdef ALARM_EN
  logic [4:0] al_h, snz_h, sh;
  logic [5:0] al_m, snz_m, sm;
  logic       al_p, snz_p, sp, snz_act, al_ok, match_al, match_sz;
  logic [6:0] snz_sum, snz_sub;

  assign al_ok  = (bus.al_minute <= 6'd59) && hour_ok(bus.al_hour);
  assign al_bad = bus.al_set && !al_ok;

  // Snooze target is taken from the displayed time, carrying into hour/pm.
  always_comb begin
    snz_sum = {1'b0, bus.minute} + 7'(SNOOZE_MIN);
    snz_sub = snz_sum - 7'd60;
    sm      = snz_sum[5:0];
    sh      = bus.hour;
    sp      = bus.pm;
    if (snz_sum >= 7'd60) begin
      sm       = snz_sub[5:0];
      {sp, sh} = hour_inc(bus.hour, bus.pm);
    end
  end

  assign match_al = tick && bus.al_arm && (n_sec == 6'd0) && (n_min == al_m) &&
                    (n_hour == al_h) && ((HOUR_MODE == 0) || (n_pm == al_p));
  assign match_sz = tick && bus.al_arm && snz_act && (n_sec == 6'd0) && (n_min == snz_m) &&
                    (n_hour == snz_h) && ((HOUR_MODE == 0) || (n_pm == snz_p));

  always_ff @(posedge clk) begin
    if (rst) begin
      al_h      <= 5'd0;
      al_m      <= 6'd0;
      al_p      <= 1'b0;
      snz_h     <= 5'd0;
      snz_m     <= 6'd0;
      snz_p     <= 1'b0;
      snz_act   <= 1'b0;
      bus.alarm <= 1'b0;
    end else begin
      if (bus.al_set && al_ok) begin
        al_h <= bus.al_hour;
        al_m <= bus.al_minute;
        al_p <= bus.al_pm;
      end
      if (match_al || match_sz) begin
        bus.alarm <= 1'b1;
      end else if (bus.snooze && bus.alarm) begin
        bus.alarm <= 1'b0;
        snz_act   <= 1'b1;
        snz_h     <= sh;
        snz_m     <= sm;
        snz_p     <= sp;
      end else if (bus.al_ack) begin
        bus.alarm <= 1'b0;
      end
      if (match_sz) snz_act <= 1'b0;
      if (!bus.al_arm || (bus.al_set && al_ok)) snz_act <= 1'b0;
    end
  end
`else
  assign al_bad    = 1'b0;
  assign bus.alarm = 1'b0;
  wire unused_alarm_inputs = &{1'b0, bus.al_set, bus.al_hour, bus.al_minute, bus.al_pm,
                               bus.al_arm, bus.al_ack, bus.snooze};
`endif
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb/tb_rtc_timekeeper.sv - randomized + directed bench for 24h and 12h instances vs seconds-of-day model
module tb_rtc_timekeeper;
  localparam int F = 4;
  localparam int S = 1;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, edit, e_pm, al_set, al_pm, al_arm, al_ack, snooze;
  logic [5:0] e_sec, e_minute, al_minute;
  logic [4:0] e_hour, al_hour;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_timekeeper_if bus0();
  rtc_timekeeper_if bus1();

  assign bus0.start = start;  assign bus0.stop = stop;  assign bus0.edit = edit;
  assign bus0.e_sec = e_sec;  assign bus0.e_minute = e_minute;  assign bus0.e_hour = e_hour;
  assign bus0.e_pm = e_pm;  assign bus0.al_set = al_set;  assign bus0.al_hour = al_hour;
  assign bus0.al_minute = al_minute;  assign bus0.al_pm = al_pm;  assign bus0.al_arm = al_arm;
  assign bus0.al_ack = al_ack;  assign bus0.snooze = snooze;
  assign bus1.start = start;  assign bus1.stop = stop;  assign bus1.edit = edit;
  assign bus1.e_sec = e_sec;  assign bus1.e_minute = e_minute;  assign bus1.e_hour = e_hour;
  assign bus1.e_pm = e_pm;  assign bus1.al_set = al_set;  assign bus1.al_hour = al_hour;
  assign bus1.al_minute = al_minute;  assign bus1.al_pm = al_pm;  assign bus1.al_arm = al_arm;
  assign bus1.al_ack = al_ack;  assign bus1.snooze = snooze;

  rtc_timekeeper #(.CLK_FRQ(F), .HOUR_MODE(0), .SNOOZE_MIN(S)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rtc_timekeeper #(.CLK_FRQ(F), .HOUR_MODE(1), .SNOOZE_MIN(S)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Model: time is seconds since midnight; state 0=IDLE 1=RUN 2=EDIT 3=STOP.
  int m_st[2], m_ph[2], m_t[2], m_al_h[2], m_al_m[2], m_snz_t[2];
  bit m_al_p[2], m_tick[2], m_err[2], m_alarm[2], m_snz[2];

  function automatic bit hour_valid(int md, int h);
    return md != 0 ? (h >= 1 && h <= 12) : (h <= 23);
  endfunction

  function automatic int to_t(int md, int h, int m, int s, bit p);
    int h24 = (md != 0) ? (h % 12) + (p ? 12 : 0) : h;
    return h24 * 3600 + m * 60 + s;
  endfunction

  function automatic logic [31:0] disp(int md, int t);
    int h24 = t / 3600;
    int h = (md != 0) ? ((h24 % 12 == 0) ? 12 : h24 % 12) : h24;
    return 32'((h << 13) | (((t / 60) % 60) << 7) | ((t % 60) << 1) | (h24 >= 12 ? 1 : 0));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d);
    int nt, nst, at;
    bit tk, e_ok, a_ok, mal, msz;
    if (rst) begin
      m_st[d] = 0; m_ph[d] = 0; m_t[d] = 0; m_al_h[d] = 0; m_al_m[d] = 0; m_al_p[d] = 0;
      m_tick[d] = 0; m_err[d] = 0; m_alarm[d] = 0; m_snz[d] = 0; m_snz_t[d] = 0;
      return;
    end
    e_ok = e_sec <= 59 && e_minute <= 59 && hour_valid(d, int'(e_hour));
    a_ok = al_minute <= 59 && hour_valid(d, int'(al_hour));
    tk   = m_st[d] == 1 && !stop && !edit && m_ph[d] == F - 1;
    nt   = m_t[d];
    nst  = m_st[d];
    case (m_st[d])
      0: begin
        m_ph[d] = 0;
        if (start) nst = 1; else if (edit) nst = 2;
      end
      1: begin
        if (stop) nst = 3;
        else if (edit) nst = 2;
        else if (tk) begin m_ph[d] = 0; nt = (nt + 1) % 86400; end
        else m_ph[d]++;
      end
      2: begin
        m_ph[d] = 0;
        if (e_ok) nt = to_t(d, int'(e_hour), int'(e_minute), int'(e_sec), e_pm);
        if (start) nst = 1; else if (stop) nst = 3; else if (!edit) nst = 0;
      end
      default: begin
        if (start) nst = 1; else if (edit) nst = 2;
      end
    endcase
    m_tick[d] = tk;
    m_err[d]  = m_st[d] == 2 && !e_ok;
`ifdef ALARM_EN
    if (al_set && !a_ok) m_err[d] = 1;
    at  = (d != 0 && m_al_h[d] == 0) ? -1 : to_t(d, m_al_h[d], m_al_m[d], 0, m_al_p[d]);
    mal = tk && al_arm && at >= 0 && nt == at;
    msz = tk && al_arm && m_snz[d] && nt == m_snz_t[d];
    if (al_set && a_ok) begin m_al_h[d] = int'(al_hour); m_al_m[d] = int'(al_minute); m_al_p[d] = al_pm; end
    if (mal || msz) m_alarm[d] = 1;
    else if (snooze && m_alarm[d]) begin
      m_alarm[d] = 0; m_snz[d] = 1;
      m_snz_t[d] = (((m_t[d] / 60) + S) % 1440) * 60;
    end else if (al_ack) m_alarm[d] = 0;
    if (msz) m_snz[d] = 0;
    if (!al_arm || (al_set && a_ok)) m_snz[d] = 0;
`else
    at = 0; mal = a_ok; msz = 0;
`endif
    m_t[d]  = nt;
    m_st[d] = nst;
  endtask

  task automatic cyc();
    logic [31:0] ot, of, om;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ot = {14'd0, bus0.hour, bus0.minute, bus0.second, bus0.pm};
        of = {29'd0, bus0.sec_tick, bus0.edit_err, bus0.alarm};
        om = {28'd0, bus0.idle_mode, bus0.run_mode, bus0.edit_mode, bus0.stop_mode};
      end else begin
        ot = {14'd0, bus1.hour, bus1.minute, bus1.second, bus1.pm};
        of = {29'd0, bus1.sec_tick, bus1.edit_err, bus1.alarm};
        om = {28'd0, bus1.idle_mode, bus1.run_mode, bus1.edit_mode, bus1.stop_mode};
      end
      check($sformatf("d%0d_time t=%0t", d, $time), ot, disp(d, m_t[d]));
      check($sformatf("d%0d_flags t=%0t", d, $time), of, {29'd0, m_tick[d], m_err[d], m_alarm[d]});
      check($sformatf("d%0d_mode t=%0t", d, $time), om, 32'(8 >> m_st[d]));
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_e(input int h, input int m, input int s, input bit p);
    e_hour = 5'(h); e_minute = 6'(m); e_sec = 6'(s); e_pm = p;
  endtask

  task automatic edit_then_start(input int h, input int m, input int s, input bit p);
    set_e(h, m, s, p);
    edit = 1; run(2);
    edit = 0; start = 1; run(1);
    start = 0;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; edit = 0; set_e(0, 0, 0, 0);
    al_set = 0; al_hour = 0; al_minute = 0; al_pm = 0; al_arm = 0; al_ack = 0; snooze = 0;
    run(2);
    rst = 0;

    edit_then_start(23, 59, 58, 0); run(12);
    edit_then_start(11, 59, 59, 0); run(6);
    edit_then_start(12, 59, 59, 1); run(6);

    edit = 1; set_e(10, 60, 0, 0); run(2);
    set_e(0, 30, 0, 0); run(2);
    set_e(13, 30, 0, 1); run(1);
    edit = 0; run(1);

    start = 1; run(1); start = 0; run(2);
    stop = 1; run(1); stop = 0; run(3);
    start = 1; run(1); start = 0; run(4);
    rst = 1; run(1); rst = 0; run(2);

    al_arm = 1; al_hour = 0; al_minute = 1; al_pm = 0;
    al_set = 1; run(1); al_set = 0;
    edit_then_start(0, 0, 59, 0); run(6);
    snooze = 1; run(1); snooze = 0; run(250);

    al_hour = 12; al_minute = 1;
    al_set = 1; run(1); al_set = 0;
    edit_then_start(12, 0, 59, 0);
    al_ack = 1; run(8); al_ack = 0; run(2);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 15) == 0);
      edit     = ($urandom_range(0, 9) == 0);
      e_sec    = 6'($urandom_range(0, 63));
      e_minute = 6'($urandom_range(0, 62));
      e_hour   = 5'($urandom_range(0, 25));
      e_pm     = 1'($urandom_range(0, 1));
      al_set   = ($urandom_range(0, 49) == 0);
      al_hour  = 5'($urandom_range(0, 24));
      al_minute= 6'($urandom_range(0, 61));
      al_pm    = 1'($urandom_range(0, 1));
      al_arm   = ($urandom_range(0, 19) != 0);
      al_ack   = ($urandom_range(0, 29) == 0);
      snooze   = ($urandom_range(0, 19) == 0);
      run(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
